// File: rtl/sr8_reorder_ctrl.sv
// Control sequencer for the 8-deep complex shift register in the radix-8 input stage.
// Fills 8 samples per group, then steps the tap select through natural or
// bit-reversed order under a valid/ready handshake, marking frame start/end.
module sr8_reorder_ctrl #(
  parameter int unsigned GROUPS = 8,
  parameter int unsigned GRP_W  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic       in_sof_i,
  input  logic       in_mode_i,
  output logic       in_ready_o,
  output logic       sr_ren_o,
  output logic [2:0] sr_sel_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_sof_o,
  output logic       out_eof_o,
  output logic       err_sof_o
);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  localparam logic [GRP_W-1:0] GrpLast = GRP_W'(GROUPS - 1);

  state_e           state_q, state_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic [2:0]       rd_cnt_q, rd_cnt_d;
  logic [GRP_W-1:0] grp_cnt_q, grp_cnt_d;
  logic             mode_q, mode_d;
  logic [2:0]       sr_sel_q, sr_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             err_sof_q, err_sof_d;
  logic             accept, xfer;
  logic [2:0]       rd_nxt;

  // Tap index for read slot k: identity or 3-bit reversal.
  function automatic logic [2:0] order(input logic m, input logic [2:0] k);
    return m ? {k[0], k[1], k[2]} : k;
  endfunction

  assign accept      = in_valid_i & (state_q == StFill);
  assign xfer        = out_valid_q & out_ready_i;
  assign rd_nxt      = rd_cnt_q + 3'd1;
  assign in_ready_o  = (state_q == StFill);
  assign sr_ren_o    = accept;
  assign sr_sel_o    = sr_sel_q;
  assign out_valid_o = out_valid_q;
  assign out_sof_o   = out_sof_q;
  assign out_eof_o   = out_eof_q;
  assign err_sof_o   = err_sof_q;

  // Next-state: fill counting, frame resync, and drain sequencing.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    grp_cnt_d   = grp_cnt_q;
    mode_d      = mode_q;
    sr_sel_d    = sr_sel_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    err_sof_d   = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (in_sof_i) begin
            // Resync: this sample becomes sample 0 of group 0; partial group is dropped.
            mode_d     = in_mode_i;
            grp_cnt_d  = '0;
            fill_cnt_d = 3'd1;
            err_sof_d  = (fill_cnt_q != 3'd0) || (grp_cnt_q != '0);
          end else if (fill_cnt_q == 3'd7) begin
            fill_cnt_d  = 3'd0;
            state_d     = StDrain;
            rd_cnt_d    = 3'd0;
            sr_sel_d    = 3'd0;
            out_valid_d = 1'b1;
            out_sof_d   = (grp_cnt_q == '0);
            out_eof_d   = 1'b0;
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end
      end
      StDrain: begin
        if (xfer) begin
          if (rd_cnt_q == 3'd7) begin
            state_d     = StFill;
            rd_cnt_d    = 3'd0;
            sr_sel_d    = 3'd0;
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            grp_cnt_d   = (grp_cnt_q == GrpLast) ? '0 : grp_cnt_q + GRP_W'(1);
          end else begin
            rd_cnt_d  = rd_nxt;
            sr_sel_d  = order(mode_q, rd_nxt);
            out_sof_d = 1'b0;
            out_eof_d = (rd_nxt == 3'd7) && (grp_cnt_q == GrpLast);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      fill_cnt_q  <= 3'd0;
      rd_cnt_q    <= 3'd0;
      grp_cnt_q   <= '0;
      mode_q      <= 1'b0;
      sr_sel_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      grp_cnt_q   <= grp_cnt_d;
      mode_q      <= mode_d;
      sr_sel_q    <= sr_sel_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      err_sof_q   <= err_sof_d;
    end
  end

endmodule

// File: tb/tb_sr8_reorder_ctrl.sv
// Bench for sr8_reorder_ctrl: models the external shift register and predicts,
// per completed group, the sequence of sample values that must appear on the
// selected tap, together with frame markers and resync errors.
module tb_sr8_reorder_ctrl;

  localparam int GROUPS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_sof, in_mode, out_ready;
  logic       in_ready, sr_ren, out_valid, out_sof, out_eof, err_sof;
  logic [2:0] sr_sel;

  sr8_reorder_ctrl #(.GROUPS(GROUPS), .GRP_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_sof_i   (in_sof),
    .in_mode_i  (in_mode),
    .in_ready_o (in_ready),
    .sr_ren_o   (sr_ren),
    .sr_sel_o   (sr_sel),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sof_o  (out_sof),
    .out_eof_o  (out_eof),
    .err_sof_o  (err_sof)
  );

  always #5 clk = ~clk;

  // External shift register driven by the DUT's shift enable; tap 7 newest.
  int din = 0;
  int sr[8];
  always @(posedge clk) begin
    if (sr_ren) begin
      for (int i = 0; i < 7; i++) sr[i] <= sr[i+1];
      sr[7] <= din;
    end
  end

  typedef struct {int val; bit sof; bit eof;} exp_t;
  exp_t exp_q[$];
  int   grp_s[$];
  int   m_grp = 0;
  bit   m_mode = 0;
  bit   err_exp = 0;
  int   n_vec = 0, n_err = 0, n_xfer = 0, n_eof = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bitrev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // One clock: drive at negedge, check, then advance the reference model.
  task automatic step(input bit iv, input bit sof, input bit md, input bit ordy);
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_sof = sof; in_mode = md; out_ready = ordy;
    din = din + 1;
    #1;
    exp_rdy = (exp_q.size() == 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("sr_ren", sr_ren, iv && exp_rdy);
    chk("out_valid", out_valid, !exp_rdy);
    chk("err_sof", err_sof, err_exp);
    if (!exp_rdy) begin
      chk("tap_data", sr[sr_sel], exp_q[0].val);
      chk("out_sof", out_sof, exp_q[0].sof);
      chk("out_eof", out_eof, exp_q[0].eof);
    end
    err_exp = 0;
    if (ordy && !exp_rdy) begin
      n_xfer++;
      if (out_eof) n_eof++;
      void'(exp_q.pop_front());
    end
    if (iv && exp_rdy) begin
      if (sof) begin
        err_exp = (grp_s.size() != 0) || (m_grp != 0);
        m_mode  = md;
        m_grp   = 0;
        grp_s.delete();
      end
      grp_s.push_back(din);
      if (grp_s.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          e.val = grp_s[m_mode ? bitrev3(k) : k];
          e.sof = (k == 0) && (m_grp == 0);
          e.eof = (k == 7) && (m_grp == GROUPS - 1);
          exp_q.push_back(e);
        end
        m_grp = (m_grp + 1) % GROUPS;
        grp_s.delete();
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sr_ren", sr_ren, 0);
    chk("rst_sr_sel", sr_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_err_sof", err_sof, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; in_sof = 0; out_ready = 0;
    #1 rst_n = 0;
    #1 chk_reset_outputs();
    exp_q.delete(); grp_s.delete();
    m_grp = 0; m_mode = 0; err_exp = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_sof = 0; in_mode = 0; out_ready = 0;
    #2 chk_reset_outputs();
    #20 rst_n = 1;

    // Natural-order group.
    step(1, 1, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Bit-reversed group (resync at group 1 flags err_sof).
    step(1, 1, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Full frame, continuous traffic.
    n_xfer = 0; n_eof = 0;
    for (int i = 0; i < 128; i++) step(1, i == 0, 0, 1);
    chk("frame_xfers", n_xfer, 64);
    chk("frame_eofs", n_eof, 1);

    // Output stall at rd_cnt=3 while upstream keeps offering data.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // Resync at fill_cnt=5 of group 2.
    for (int i = 0; i < 16; i++) step(i < 8, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    step(1, 1, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // Randomized traffic with occasional resyncs and stalls.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);

    // Reset in the middle of a drain at rd_cnt=4.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sr8_reorder_ctrl.md
Name: sr8_reorder_ctrl

Overview:
- Sequencer for the 8-deep complex shift register (10-bit re/im) in the 64-point FFT radix-8 input stage.
- Accepts a sample stream and shifts exactly 8 samples per group into the register.
- Then reads the 8 taps out in natural or bit-reversed order under valid/ready handshake.
- Tracks 8 groups per 64-point frame and emits frame markers; datapath stays in the register, this block drives only its controls.

Parameters:
- GROUPS, 8, groups per frame (64 points / 8); range 2..16.
- GRP_W, 3, width of group counter; must equal ceil(log2(GROUPS)).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- in_valid  input  1  upstream sample valid
- in_sof  input  1  first sample of frame; qualified by in_valid
- in_mode  input  1  order for frame: 0 natural, 1 bit-reversed; sampled with accepted in_sof
- in_ready  output  1  block can accept a sample
- sr_ren  output  1  shift enable to the shift register
- sr_sel  output  3  tap select to the shift register
- out_valid  output  1  sr_sel addresses a valid output sample
- out_ready  input  1  downstream accepts the sample
- out_sof  output  1  first output sample of frame
- out_eof  output  1  last (64th) output sample of frame
- err_sof  output  1  one-cycle pulse: in_sof arrived off group/frame boundary

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk.
- Reset values: state FILL, fill_cnt=0, rd_cnt=0, grp_cnt=0, mode=0.
- Reset output values: sr_sel=0, out_valid=0, out_sof=0, out_eof=0, err_sof=0, in_ready=1, sr_ren=0.
- Reset mid-operation drops any partial group; no output is produced for it.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Combinational outputs:
  - in_ready = (state==FILL).
  - sr_ren = accept, same cycle.
- FILL state:
  - On each accept, fill_cnt increments.
  - On the accept with fill_cnt==7: fill_cnt=0, state becomes DRAIN, rd_cnt=0.
  - On the same edge, sr_sel and out_valid load for k=0.
- Shift register contents after a full fill: tap 0 = oldest sample (1st accepted), tap 7 = newest.
- DRAIN state:
  - in_ready=0 and sr_ren=0; the register is frozen.
  - out_valid is registered and stays 1.
  - sr_sel is registered = order(rd_cnt).
  - order(k) = k when mode=0; {k[0],k[1],k[2]} when mode=1.
  - On each output transfer, rd_cnt increments and sr_sel updates on the same edge.
  - If out_ready stays low, sr_sel/out_valid/out_sof/out_eof are held.
- End of group:
  - Transfer at rd_cnt==7 returns to FILL: out_valid=0, sr_sel=0.
  - grp_cnt increments on that transfer, wrapping from GROUPS-1 to 0.
- Frame markers (registered, valid only while out_valid=1):
  - out_sof = (rd_cnt==0 & grp_cnt==0).
  - out_eof = (rd_cnt==7 & grp_cnt==GROUPS-1).
- Latency: 8th accept at edge t gives out_valid=1 after edge t. Max throughput is 8 outputs per 16 cycles.
- Frame resync (in FILL, accept with in_sof=1):
  - mode <= in_mode.
  - grp_cnt <= 0.
  - fill_cnt <= 1, so that sample is sample 0 of the group.
  - If fill_cnt!=0 or grp_cnt!=0 beforehand: err_sof=1 for the next cycle only. The partial group is discarded, and the stale register contents are flushed by the next 8 shifts.
- in_sof while in DRAIN is not accepted (in_ready=0). Upstream must hold it.
- Before the first in_sof after reset, data is treated as frame start with mode=0.
- mode changes only at an accepted in_sof; the current frame's order is never altered mid-group.

Test Plan:
- Reset, then 8 accepts (in_sof on first, mode=0), out_ready=1 → sr_ren high 8 cycles; out_valid next cycle; sr_sel 0,1,...,7; out_sof only on sel 0; err_sof=0.
- Same with mode=1 → sr_sel sequence 0,4,2,6,1,5,3,7.
- Full 64-sample frame, continuous in_valid/out_ready → in_ready alternates 8 high/8 low; exactly 64 output transfers; out_eof only on the 64th; grp_cnt wraps to 0.
- out_ready low 5 cycles at rd_cnt=3 → sr_sel held at order(3), out_valid held at 1, in_ready=0, no sr_ren.
- in_sof at fill_cnt=5 of group 2 → err_sof pulse one cycle; next 7 accepts complete the group; its drain has out_sof=1 on sel 0.
- Assert rst_n low mid-DRAIN (rd_cnt=4) → outputs at reset values immediately, in_ready=1 after release, no further output for the dropped group.
